// File: rtl/z80_bus_pkg.sv
// ============================================================================
// Module : z80_bus_pkg
// Brief  : Shared types and constants for the Z80 bus responder and tracer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package z80_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_DRV = 3'd2,
        ST_WR_ARM = 3'd3,
        ST_WR_REQ = 3'd4,
        ST_WR_END = 3'd5,
        ST_ABORT  = 3'd6
    } resp_state_t;

    typedef struct packed {
        logic M1_n;
        logic MREQ_n;
        logic IORQ_n;
        logic RD_n;
        logic WR_n;
        logic RFSH_n;
    } z80_ctrl_t;

    // Value a floating (pulled-up) data bus reads as; returned on aborted reads.
    localparam byte Z80_FLOAT_BYTE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/z80_cycle_decode.sv
// ============================================================================
// Module : z80_cycle_decode
// Brief  : Combinational Z80 cycle classifier (read / write-pending / INTA).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module z80_cycle_decode
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] MEM_BASE = 16'h8000,
    parameter logic [15:0] MEM_MASK = 16'hC000,
    parameter logic [7:0]  IO_PORT  = 8'h10
) (
    input  z80_ctrl_t   ctrl_i,
    input  logic [15:0] addr_i,
    output logic        rd_o,
    output logic        wrpd_o,
    output logic        inta_o,
    output logic        io_o,
    output logic        wr_act_o,
    output logic        cycle_end_o
);

    logic w_mem_hit;
    logic w_io_hit;
    logic w_mem_sel;
    logic w_io_sel;

    assign w_mem_hit = (addr_i & MEM_MASK) == MEM_BASE;
    assign w_io_hit  = addr_i[7:0] == IO_PORT;
    assign w_mem_sel = w_mem_hit & ~ctrl_i.MREQ_n;
    assign w_io_sel  = w_io_hit & ~ctrl_i.IORQ_n & ctrl_i.M1_n;

    // Refresh cycles put a row address on A that may alias the window; never claim them.
    assign rd_o        = ~ctrl_i.RD_n & ctrl_i.RFSH_n & (w_mem_sel | w_io_sel);
    assign wrpd_o      = ctrl_i.RD_n & ctrl_i.RFSH_n & ((w_mem_sel & ctrl_i.M1_n) | w_io_sel);
    assign inta_o      = ~ctrl_i.M1_n & ~ctrl_i.IORQ_n;
    assign io_o        = ~ctrl_i.IORQ_n;
    assign wr_act_o    = ~ctrl_i.WR_n;
    assign cycle_end_o = ctrl_i.MREQ_n & ctrl_i.IORQ_n;

endmodule

`default_nettype wire

// File: rtl/z80_bus_responder.sv
// ============================================================================
// Module : z80_bus_responder
// Brief  : Target-side Z80 bus agent bridging one memory window and one IO
//          port to a req/ack backend, stretching cycles with WAIT_n.
//          Optional macro Z80_RESP_INTA_EN answers interrupt acknowledge.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter logic [15:0] MEM_BASE    = 16'h8000,
    parameter logic [15:0] MEM_MASK    = 16'hC000,
    parameter logic [7:0]  IO_PORT     = 8'h10,
    parameter int          ACK_TIMEOUT = 64,
    parameter logic [7:0]  INTA_VECTOR = 8'hFF
) (
    input  logic        CLK_n,
    input  logic        RESET,
    input  logic        M1_n,
    input  logic        MREQ_n,
    input  logic        IORQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        RFSH_n,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        WAIT_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        err_sticky
);

    localparam int                 c_cnt_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

    z80_ctrl_t w_ctrl;
    logic      w_rd;
    logic      w_wrpd;
    logic      w_inta;
    logic      w_io;
    logic      w_wr_act;
    logic      w_cycle_end;
    logic      w_inta_claim;

    resp_state_t        state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic [7:0]         d_out_q;
    logic               d_oe_q;
    logic               wait_n_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic               mem_io_q;
    logic [15:0]        mem_addr_q;
    logic [7:0]         mem_wdata_q;
    logic               err_q;

    assign w_ctrl = {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n};

    z80_cycle_decode #(
        .MEM_BASE (MEM_BASE),
        .MEM_MASK (MEM_MASK),
        .IO_PORT  (IO_PORT)
    ) u_decode (
        .ctrl_i      (w_ctrl),
        .addr_i      (A),
        .rd_o        (w_rd),
        .wrpd_o      (w_wrpd),
        .inta_o      (w_inta),
        .io_o        (w_io),
        .wr_act_o    (w_wr_act),
        .cycle_end_o (w_cycle_end)
    );

`ifdef Z80_RESP_INTA_EN
    assign w_inta_claim = w_inta;
`else
    logic unused_inta;
    assign w_inta_claim = 1'b0;
    assign unused_inta  = w_inta;
`endif

    always_ff @(posedge CLK_n or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            wait_n_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_io_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // INTA drive is held for as long as IORQ_n stays low.
                    d_oe_q <= w_inta_claim;
                    if (w_inta_claim) begin
                        d_out_q <= INTA_VECTOR;
                    end
                    if (w_rd) begin
                        state_q    <= ST_RD_REQ;
                        wait_n_q   <= 1'b0;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_io_q   <= w_io;
                        mem_addr_q <= A;
                        cnt_q      <= '0;
                    end else if (w_wrpd) begin
                        state_q  <= ST_WR_ARM;
                        wait_n_q <= 1'b0;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ack) begin
                        state_q   <= ST_RD_DRV;
                        d_out_q   <= mem_rdata;
                        d_oe_q    <= 1'b1;
                        wait_n_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_q   <= ST_ABORT;
                        d_out_q   <= Z80_FLOAT_BYTE;
                        d_oe_q    <= 1'b1;
                        wait_n_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RD_DRV: begin
                    if (RD_n || w_cycle_end) begin
                        state_q <= ST_IDLE;
                        d_oe_q  <= 1'b0;
                    end
                end
                ST_WR_ARM: begin
                    if (w_cycle_end) begin
                        state_q  <= ST_IDLE;
                        wait_n_q <= 1'b1;
                    end else if (w_wr_act) begin
                        state_q     <= ST_WR_REQ;
                        mem_wdata_q <= D_in;
                        mem_addr_q  <= A;
                        mem_io_q    <= w_io;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        cnt_q       <= '0;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_ack) begin
                        state_q   <= ST_WR_END;
                        wait_n_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                    end else if (cnt_q == c_cnt_last) begin
                        state_q   <= ST_ABORT;
                        wait_n_q  <= 1'b1;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WR_END: begin
                    if (!w_wr_act) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    // One dead cycle so a late ack lands here and is dropped.
                    if (mem_we_q) begin
                        state_q <= ST_WR_END;
                    end else if (RD_n || w_cycle_end) begin
                        state_q <= ST_IDLE;
                        d_oe_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RD_DRV;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign D_out      = d_out_q;
    assign D_oe       = d_oe_q;
    assign WAIT_n     = wait_n_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_io     = mem_io_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign err_sticky = err_q;

endmodule

`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
// ============================================================================
// Module : tb_z80_bus_responder
// Brief  : Self-checking bench for z80_bus_responder (table + random vectors).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_z80_bus_responder;

    localparam int TMO = 64;

    typedef enum int {K_MRD, K_M1, K_MWR, K_IORD, K_IOWR, K_RFSH, K_INTA} kind_e;

    typedef struct {
        kind_e       kind;
        logic [15:0] addr;
        logic [7:0]  data;
        int          delay;
        bit          exp_claim;
        int          exp_wait;
        logic [7:0]  exp_rd;
    } vec_t;

    logic        CLK_n = 1'b0;
    logic        RESET = 1'b1;
    logic        M1_n = 1'b1, MREQ_n = 1'b1, IORQ_n = 1'b1;
    logic        RD_n = 1'b1, WR_n = 1'b1, RFSH_n = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe, WAIT_n, mem_req, mem_we, mem_io;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;
    bit err_m  = 1'b0;
    vec_t vecs[$];

    always #5 CLK_n = ~CLK_n;

    z80_bus_responder #(
        .MEM_BASE    (16'h8000),
        .MEM_MASK    (16'hC000),
        .IO_PORT     (8'h10),
        .ACK_TIMEOUT (TMO),
        .INTA_VECTOR (8'hE7)
    ) dut (
        .CLK_n      (CLK_n),
        .RESET      (RESET),
        .M1_n       (M1_n),
        .MREQ_n     (MREQ_n),
        .IORQ_n     (IORQ_n),
        .RD_n       (RD_n),
        .WR_n       (WR_n),
        .RFSH_n     (RFSH_n),
        .A          (A),
        .D_in       (D_in),
        .D_out      (D_out),
        .D_oe       (D_oe),
        .WAIT_n     (WAIT_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_io     (mem_io),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .err_sticky (err_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dout"}, D_out, 8'h00);
        chk({tag, "_doe"}, D_oe, 1'b0);
        chk({tag, "_wait"}, WAIT_n, 1'b1);
        chk({tag, "_req"}, mem_req, 1'b0);
        chk({tag, "_we"}, mem_we, 1'b0);
        chk({tag, "_io"}, mem_io, 1'b0);
        chk({tag, "_addr"}, mem_addr, 16'h0000);
        chk({tag, "_wdata"}, mem_wdata, 8'h00);
        chk({tag, "_err"}, err_sticky, 1'b0);
    endtask

    // Reference: window is 0x8000..0xBFFF, IO port is low byte 0x10.
    function automatic bit m_claim(input kind_e k, input logic [15:0] a);
        bit in_win;
        bit io_port;
        in_win  = (a >= 16'h8000) && (a <= 16'hBFFF);
        io_port = (a % 256) == 16;
        case (k)
            K_MRD, K_M1, K_MWR: return in_win;
            K_IORD, K_IOWR:     return io_port;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic vec_t mk_model(input kind_e k, input logic [15:0] a,
                                      input logic [7:0] d, input int dly);
        vec_t v;
        bit   acked;
        v.kind      = k;
        v.addr      = a;
        v.data      = d;
        v.delay     = dly;
        acked       = (dly >= 1) && (dly <= TMO);
        v.exp_claim = m_claim(k, a);
        v.exp_wait  = (v.exp_claim && k != K_RFSH && k != K_INTA) ? (acked ? dly : TMO) : 0;
        v.exp_rd    = acked ? d : 8'hFF;
        return v;
    endfunction

    function automatic vec_t mk(input kind_e k, input logic [15:0] a, input logic [7:0] d,
                                input int dly, input bit cl, input int w, input logic [7:0] rdv);
        vec_t v;
        v.kind = k; v.addr = a; v.data = d; v.delay = dly;
        v.exp_claim = cl; v.exp_wait = w; v.exp_rd = rdv;
        return v;
    endfunction

    task automatic release_bus();
        RD_n = 1'b1; WR_n = 1'b1; MREQ_n = 1'b1; IORQ_n = 1'b1; M1_n = 1'b1; RFSH_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        bit is_rd, is_wr, is_io, tmo;
        int waits;
        is_rd = v.kind inside {K_MRD, K_M1, K_IORD};
        is_wr = v.kind inside {K_MWR, K_IOWR};
        is_io = v.kind inside {K_IORD, K_IOWR, K_INTA};
        tmo   = v.exp_claim && (is_rd || is_wr) && !(v.delay >= 1 && v.delay <= TMO);
        @(negedge CLK_n);
        A      = v.addr;
        M1_n   = !(v.kind inside {K_M1, K_INTA});
        MREQ_n = !(v.kind inside {K_MRD, K_M1, K_MWR, K_RFSH});
        IORQ_n = !is_io;
        RD_n   = !is_rd;
        RFSH_n = (v.kind != K_RFSH);
        D_in   = 8'($urandom);
        @(negedge CLK_n);
        chk("req_after_decode", mem_req, is_rd && v.exp_claim);
        chk("wait_after_decode", WAIT_n, !v.exp_claim);
        if (v.kind == K_INTA) begin
`ifdef Z80_RESP_INTA_EN
            chk("inta_oe", D_oe, 1'b1);
            chk("inta_vec", D_out, 8'hE7);
`else
            chk("inta_oe", D_oe, 1'b0);
`endif
        end else if (!is_rd) begin
            chk("oe_quiet", D_oe, 1'b0);
        end
        if (is_rd && v.exp_claim) begin
            chk("rd_addr", mem_addr, v.addr);
            chk("rd_we", mem_we, 1'b0);
            chk("rd_io", mem_io, is_io);
        end
        if (is_wr) begin
            WR_n = 1'b0;
            D_in = v.data;
            @(negedge CLK_n);
            chk("wr_req", mem_req, v.exp_claim);
            if (v.exp_claim) begin
                chk("wr_we", mem_we, 1'b1);
                chk("wr_addr", mem_addr, v.addr);
                chk("wr_wdata", mem_wdata, v.data);
                chk("wr_io", mem_io, is_io);
            end
        end
        waits = 0;
        while (WAIT_n === 1'b0 && waits < TMO + 8) begin
            if (v.delay >= 1 && waits == v.delay - 1) begin
                mem_ack   = 1'b1;
                mem_rdata = v.data;
            end else begin
                mem_rdata = 8'($urandom);
            end
            @(negedge CLK_n);
            mem_ack = 1'b0;
            waits++;
        end
        chk("wait_cycles", waits, v.exp_wait);
        if (tmo) err_m = 1'b1;
        chk("err_sticky", err_sticky, err_m);
        chk("req_done", mem_req, 1'b0);
        if (is_rd && v.exp_claim) begin
            chk("rd_oe", D_oe, 1'b1);
            chk("rd_data", D_out, v.exp_rd);
        end
        if (tmo) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'h3C;
            @(negedge CLK_n);
            mem_ack = 1'b0;
            chk("late_ack_req", mem_req, 1'b0);
            chk("late_ack_wait", WAIT_n, 1'b1);
            if (is_rd) chk("late_ack_data", D_out, 8'hFF);
        end
        release_bus();
        @(negedge CLK_n);
        chk("end_oe", D_oe, 1'b0);
        chk("end_wait", WAIT_n, 1'b1);
        chk("end_req", mem_req, 1'b0);
    endtask

    initial begin
        logic [15:0] bnd [6];
        logic [7:0]  hi;
        logic [15:0] ad;
        int          dly;
        kind_e       k;
        bnd = '{16'h7FFF, 16'h8000, 16'hBFFF, 16'hC000, 16'h0010, 16'hFF10};

        // Directed table: expectations written out by hand.
        vecs.push_back(mk(K_MRD,  16'h8123, 8'h5A, 3,  1, 3,   8'h5A));
        vecs.push_back(mk(K_MWR,  16'hBFFF, 8'hC3, 2,  1, 2,   8'hFF));
        vecs.push_back(mk(K_RFSH, 16'h8007, 8'h00, 1,  0, 0,   8'hFF));
        vecs.push_back(mk(K_MRD,  16'h4000, 8'h00, 1,  0, 0,   8'hFF));
        vecs.push_back(mk(K_MRD,  16'hC000, 8'h00, 1,  0, 0,   8'hFF));
        vecs.push_back(mk(K_MRD,  16'h7FFF, 8'h00, 1,  0, 0,   8'hFF));
        vecs.push_back(mk(K_M1,   16'h8000, 8'h11, 1,  1, 1,   8'h11));
        vecs.push_back(mk(K_MRD,  16'h9000, 8'hA5, 64, 1, 64,  8'hA5));
        vecs.push_back(mk(K_IOWR, 16'hAB10, 8'h77, 5,  1, 5,   8'hFF));
        vecs.push_back(mk(K_IOWR, 16'h0011, 8'h77, 1,  0, 0,   8'hFF));
        vecs.push_back(mk(K_INTA, 16'h0010, 8'h00, 1,  0, 0,   8'hFF));
        vecs.push_back(mk(K_IORD, 16'h3410, 8'h99, 0,  1, 64,  8'hFF));
        vecs.push_back(mk(K_MRD,  16'hA000, 8'h42, 2,  1, 2,   8'h42));

        // Random vectors judged by the reference model.
        for (int i = 0; i < 40; i++) begin
            k  = kind_e'($urandom_range(0, 6));
            hi = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       ad = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
                1:       ad = {hi, 8'h10};
                2:       ad = bnd[$urandom_range(0, 5)];
                default: ad = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       dly = 0;
                    1:       dly = 63;
                    2:       dly = 64;
                    default: dly = 65;
                endcase
            end else begin
                dly = $urandom_range(1, 6);
            end
            vecs.push_back(mk_model(k, ad, 8'($urandom), dly));
        end

        @(negedge CLK_n);
        chk_reset_vals("por");
        RESET = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Write decoded but the cycle ends before WR_n: WAIT released, no request.
        @(negedge CLK_n);
        A = 16'h8100; MREQ_n = 1'b0;
        @(negedge CLK_n);
        chk("arm_wait", WAIT_n, 1'b0);
        MREQ_n = 1'b1;
        @(negedge CLK_n);
        chk("arm_abandon_wait", WAIT_n, 1'b1);
        chk("arm_abandon_req", mem_req, 1'b0);

        // Stray ack while idle changes nothing.
        mem_ack = 1'b1; mem_rdata = 8'h55;
        @(negedge CLK_n);
        mem_ack = 1'b0;
        chk("stray_req", mem_req, 1'b0);
        chk("stray_oe", D_oe, 1'b0);
        chk("stray_wait", WAIT_n, 1'b1);

        // Asynchronous reset in the middle of a pending read.
        A = 16'h8055; MREQ_n = 1'b0; RD_n = 1'b0;
        repeat (3) @(negedge CLK_n);
        chk("pre_rst_req", mem_req, 1'b1);
        #2 RESET = 1'b1;
        #1 chk_reset_vals("async_rst");
        mem_ack = 1'b1;
        release_bus();
        @(negedge CLK_n);
        mem_ack = 1'b0;
        RESET   = 1'b0;
        err_m   = 1'b0;
        chk("post_rst_req", mem_req, 1'b0);
        run_vec(mk(K_MRD, 16'h8000, 8'h9E, 2, 1, 2, 8'h9E));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
